// File: rtl/pga_auto_gain_ctrl.sv
// pga_auto_gain_ctrl
//   Per-measurement automatic gain controller for the two PGA channels.
//   CALIBRATE sweeps every measurement index, lowering each channel's gain until the
//   ADC out-of-range flag stays clear for a whole observation window, and stores the
//   result in a per-index gain table. RUN drives PGA1/PGA2 from that table using the
//   measurement index supplied by the switch sequencer.
//   Optional build macro: PGA_AGC_HEADROOM_EN - store each found gain one step lower
//   (floor 0) so every entry carries one gain step of headroom.
module pga_auto_gain_ctrl #(
    parameter int          NMEAS    = 66,
    parameter int          SETTLE   = 64,
    parameter int          WIN      = 256,
    parameter logic [2:0]  DEF_GAIN = 3'b011
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CalStart,
    input  logic        CalAbort,
    input  logic        SetTrig,
    input  logic [15:0] Cmd,
    input  logic        SampleValid,
    input  logic        ADOtr1,
    input  logic        ADOtr2,
    input  logic [8:0]  SwitchAddr,
    output logic        CalActive,
    output logic [8:0]  CalAddr,
    output logic        CalDone,
    output logic [1:0]  CalErr,
    output logic [2:0]  PGA1,
    output logic [2:0]  PGA2
);

    localparam int SW = $clog2(SETTLE) + 1;
    localparam int WW = $clog2(WIN) + 1;
    localparam int AW = (NMEAS > 1) ? $clog2(NMEAS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_OBSERVE, S_ADJUST, S_STORE, S_NEXT, S_DONE
    } state_t;

    // Saturating one-step gain reduction (never wraps below code 0).
    function automatic logic [2:0] gain_dec(input logic [2:0] g);
        if (g != 3'd0) begin
            return g - 3'd1;
        end else begin
            return 3'd0;
        end
    endfunction

    state_t          state_r, state_s;
    logic [SW-1:0]   settle_cnt_r, settle_cnt_s;
    logic [WW-1:0]   win_cnt_r, win_cnt_s;
    logic            ovf1_r, ovf1_s, ovf2_r, ovf2_s;
    logic [2:0]      gain1_r, gain1_s, gain2_r, gain2_s;
    logic [8:0]      cal_addr_r, cal_addr_s;
    logic [1:0]      cal_err_r, cal_err_s;
    logic            cal_active_r, cal_active_s;
    logic            cal_done_r, cal_done_s;
    logic            store_we_s;
    logic            dec1_s, dec2_s;
    logic [2:0]      store1_s, store2_s;

    logic [8:0]      addr_r;
    logic [2:0]      pga1_r, pga2_r;
    logic [2:0]      tab1_r [NMEAS];
    logic [2:0]      tab2_r [NMEAS];
    logic [AW-1:0]   wr_idx_s, rd_idx_s;
    logic            rd_hit_s;
    logic            set_all_s;
    logic            unused_cmd_s;

    // Only the two gain fields of Cmd carry meaning here.
    assign unused_cmd_s = ^{Cmd[15], Cmd[11], Cmd[7:0]};

    assign dec1_s    = ovf1_r && (gain1_r != 3'd0);
    assign dec2_s    = ovf2_r && (gain2_r != 3'd0);
    assign wr_idx_s  = AW'(cal_addr_r - 9'd1);
    assign rd_idx_s  = AW'(addr_r - 9'd1);
    assign rd_hit_s  = (addr_r != 9'd0) && (addr_r <= 9'(NMEAS));
    assign set_all_s = SetTrig && !cal_active_r;

    // Value written to the table when a measurement index is finished.
    always_comb begin
`ifdef PGA_AGC_HEADROOM_EN
        store1_s = gain_dec(gain1_r);
        store2_s = gain_dec(gain2_r);
`else
        store1_s = gain1_r;
        store2_s = gain2_r;
`endif
    end

    // Calibration FSM: next state and next values of every sweep register.
    always_comb begin
        state_s      = state_r;
        settle_cnt_s = settle_cnt_r;
        win_cnt_s    = win_cnt_r;
        ovf1_s       = ovf1_r;
        ovf2_s       = ovf2_r;
        gain1_s      = gain1_r;
        gain2_s      = gain2_r;
        cal_addr_s   = cal_addr_r;
        cal_err_s    = cal_err_r;
        cal_active_s = cal_active_r;
        cal_done_s   = 1'b0;
        store_we_s   = 1'b0;
        if (CalAbort && (state_r != S_IDLE)) begin
            // Abort drops straight back to RUN; stored entries stay as they are.
            state_s      = S_IDLE;
            cal_active_s = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (CalStart && !CalAbort) begin
                        cal_addr_s   = 9'd1;
                        cal_err_s    = 2'b00;
                        gain1_s      = 3'b111;
                        gain2_s      = 3'b111;
                        cal_active_s = 1'b1;
                        settle_cnt_s = {SW{1'b0}};
                        state_s      = S_SETTLE;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt_r == SW'(SETTLE - 1)) begin
                        settle_cnt_s = {SW{1'b0}};
                        win_cnt_s    = {WW{1'b0}};
                        ovf1_s       = 1'b0;
                        ovf2_s       = 1'b0;
                        state_s      = S_OBSERVE;
                    end else begin
                        settle_cnt_s = settle_cnt_r + SW'(1);
                    end
                end
                S_OBSERVE: begin
                    if (SampleValid) begin
                        ovf1_s = ovf1_r | ADOtr1;
                        ovf2_s = ovf2_r | ADOtr2;
                        if (win_cnt_r == WW'(WIN - 1)) begin
                            win_cnt_s = {WW{1'b0}};
                            state_s   = S_ADJUST;
                        end else begin
                            win_cnt_s = win_cnt_r + WW'(1);
                        end
                    end else begin
                        state_s = S_OBSERVE;
                    end
                end
                S_ADJUST: begin
                    // Gains only ever move down; an overflow at code 0 is flagged instead.
                    if (ovf1_r) begin
                        gain1_s = gain_dec(gain1_r);
                        if (gain1_r == 3'd0) begin
                            cal_err_s[0] = 1'b1;
                        end else begin
                            cal_err_s[0] = cal_err_r[0];
                        end
                    end else begin
                        gain1_s = gain1_r;
                    end
                    if (ovf2_r) begin
                        gain2_s = gain_dec(gain2_r);
                        if (gain2_r == 3'd0) begin
                            cal_err_s[1] = 1'b1;
                        end else begin
                            cal_err_s[1] = cal_err_r[1];
                        end
                    end else begin
                        gain2_s = gain2_r;
                    end
                    if (dec1_s || dec2_s) begin
                        settle_cnt_s = {SW{1'b0}};
                        state_s      = S_SETTLE;
                    end else begin
                        state_s = S_STORE;
                    end
                end
                S_STORE: begin
                    store_we_s = 1'b1;
                    state_s    = S_NEXT;
                end
                S_NEXT: begin
                    if (cal_addr_r == 9'(NMEAS)) begin
                        state_s = S_DONE;
                    end else begin
                        cal_addr_s   = cal_addr_r + 9'd1;
                        gain1_s      = 3'b111;
                        gain2_s      = 3'b111;
                        settle_cnt_s = {SW{1'b0}};
                        state_s      = S_SETTLE;
                    end
                end
                S_DONE: begin
                    cal_done_s   = 1'b1;
                    cal_active_s = 1'b0;
                    state_s      = S_IDLE;
                end
                default: begin
                    cal_active_s = 1'b0;
                    state_s      = S_IDLE;
                end
            endcase
        end
    end

    // Sweep state and control registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r      <= S_IDLE;
            settle_cnt_r <= {SW{1'b0}};
            win_cnt_r    <= {WW{1'b0}};
            ovf1_r       <= 1'b0;
            ovf2_r       <= 1'b0;
            gain1_r      <= DEF_GAIN;
            gain2_r      <= DEF_GAIN;
            cal_addr_r   <= 9'd1;
            cal_err_r    <= 2'b00;
            cal_active_r <= 1'b0;
            cal_done_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            settle_cnt_r <= settle_cnt_s;
            win_cnt_r    <= win_cnt_s;
            ovf1_r       <= ovf1_s;
            ovf2_r       <= ovf2_s;
            gain1_r      <= gain1_s;
            gain2_r      <= gain2_s;
            cal_addr_r   <= cal_addr_s;
            cal_err_r    <= cal_err_s;
            cal_active_r <= cal_active_s;
            cal_done_r   <= cal_done_s;
        end
    end

    // Gain tables: reset/broadcast fill every entry, calibration writes one index.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NMEAS; i++) begin
                tab1_r[i] <= DEF_GAIN;
                tab2_r[i] <= DEF_GAIN;
            end
        end else if (set_all_s) begin
            for (int i = 0; i < NMEAS; i++) begin
                tab1_r[i] <= Cmd[14:12];
                tab2_r[i] <= Cmd[10:8];
            end
        end else if (store_we_s) begin
            tab1_r[wr_idx_s] <= store1_s;
            tab2_r[wr_idx_s] <= store2_s;
        end else begin
            tab1_r[wr_idx_s] <= tab1_r[wr_idx_s];
            tab2_r[wr_idx_s] <= tab2_r[wr_idx_s];
        end
    end

    // PGA drive: trial gains while sweeping, otherwise the table entry for the registered index.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            addr_r <= 9'd0;
            pga1_r <= DEF_GAIN;
            pga2_r <= DEF_GAIN;
        end else begin
            addr_r <= SwitchAddr;
            if (cal_active_r) begin
                pga1_r <= gain1_r;
                pga2_r <= gain2_r;
            end else if (rd_hit_s) begin
                pga1_r <= tab1_r[rd_idx_s];
                pga2_r <= tab2_r[rd_idx_s];
            end else begin
                pga1_r <= DEF_GAIN;
                pga2_r <= DEF_GAIN;
            end
        end
    end

    assign CalActive = cal_active_r;
    assign CalAddr   = cal_addr_r;
    assign CalDone   = cal_done_r;
    assign CalErr    = cal_err_r;
    assign PGA1      = pga1_r;
    assign PGA2      = pga2_r;

endmodule

// File: tb/tb_pga_auto_gain_ctrl.sv
// tb_pga_auto_gain_ctrl
//   Scenario-task bench for pga_auto_gain_ctrl (66 indices, short settle/window).
//   Expected PGA codes are queued when an index is driven and compared once the
//   two-cycle lookup latency has elapsed.
module tb_pga_auto_gain_ctrl;

    localparam int NM = 66;
    localparam int ST = 4;
    localparam int WN = 8;
`ifdef PGA_AGC_HEADROOM_EN
    localparam bit HR = 1'b1;
`else
    localparam bit HR = 1'b0;
`endif
    localparam logic [2:0] G_CH1_FOUND = HR ? 3'd3 : 3'd4;
    localparam logic [2:0] G_TOP       = HR ? 3'd6 : 3'd7;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        CalStart = 1'b0, CalAbort = 1'b0, SetTrig = 1'b0;
    logic [15:0] Cmd = 16'h0000;
    logic        SampleValid = 1'b0, ADOtr1 = 1'b0, ADOtr2 = 1'b0;
    logic [8:0]  SwitchAddr = 9'd5;
    logic        CalActive, CalDone;
    logic [8:0]  CalAddr;
    logic [1:0]  CalErr;
    logic [2:0]  PGA1, PGA2;

    int checks = 0;
    int failures = 0;
    logic [5:0] sbq [$];
    bit sv_en = 1'b0, ovf1_mode = 1'b0, ovf2_mode = 1'b0;

    pga_auto_gain_ctrl #(.NMEAS(NM), .SETTLE(ST), .WIN(WN), .DEF_GAIN(3'b011)) dut (
        .CLK(CLK), .RST(RST), .CalStart(CalStart), .CalAbort(CalAbort), .SetTrig(SetTrig),
        .Cmd(Cmd), .SampleValid(SampleValid), .ADOtr1(ADOtr1), .ADOtr2(ADOtr2),
        .SwitchAddr(SwitchAddr), .CalActive(CalActive), .CalAddr(CalAddr), .CalDone(CalDone),
        .CalErr(CalErr), .PGA1(PGA1), .PGA2(PGA2)
    );

    always #5 CLK = ~CLK;

    // ADC model: a sample every other cycle; ch1 overflows above gain 4, ch2 on demand.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            SampleValid = sv_en ? ~SampleValid : 1'b0;
            ADOtr1 = SampleValid && ovf1_mode && (PGA1 > 3'd4);
            ADOtr2 = SampleValid && ovf2_mode;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_addr(input logic [8:0] a, input logic [2:0] e1, input logic [2:0] e2);
        SwitchAddr = a;
        sbq.push_back({e1, e2});
        tick();
        tick();
    endtask

    task automatic start_cal();
        CalStart = 1'b1;
        tick();
        CalStart = 1'b0;
        tick();
    endtask

    task automatic wait_cal(input int budget, output int done_cnt, output bit timeout,
                            output int ndec, output int nbad);
        logic [2:0] last;
        done_cnt = 0; timeout = 1'b1; ndec = 0; nbad = 0; last = PGA2;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (CalDone) done_cnt++;
            if (CalActive && (CalAddr == 9'd1) && (PGA2 != last)) begin
                if (PGA2 == last - 3'd1) ndec++;
                else nbad++;
                last = PGA2;
            end
            if ((done_cnt > 0) && !CalActive) begin
                timeout = 1'b0;
                break;
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (CalDone) done_cnt++;
        end
    endtask

    task automatic test_reset();
        SwitchAddr = 9'd5;
        RST = 1'b0;
        tick(); tick();
        RST = 1'b1;
        tick(); tick();
        checks++;
        if ({PGA1, PGA2} !== 6'b011011) begin
            failures++; $display("FAIL reset_pga got=%0d/%0d want=3/3", PGA1, PGA2);
        end
        checks++;
        if ({CalActive, CalDone, CalErr} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got act=%b done=%b err=%b want 0/0/00", CalActive, CalDone, CalErr);
        end
        checks++;
        if (CalAddr !== 9'd1) begin
            failures++; $display("FAIL reset_caladdr got=%0d want=1", CalAddr);
        end
    endtask

    task automatic test_settrig();
        logic [5:0] e;
        SwitchAddr = 9'd1;
        tick();
        Cmd = 16'h5505;
        SetTrig = 1'b1;
        tick();
        SetTrig = 1'b0;
        sbq.push_back({3'd5, 3'd5});
        tick();
        e = sbq.pop_front();
        checks++;
        if ({PGA1, PGA2} !== e) begin
            failures++; $display("FAIL settrig_next got=%0d/%0d want=%0d/%0d", PGA1, PGA2, e[5:3], e[2:0]);
        end
        for (int a = 1; a <= NM; a++) begin
            drive_addr(9'(a), 3'd5, 3'd5);
            e = sbq.pop_front();
            checks++;
            if ({PGA1, PGA2} !== e) begin
                failures++; $display("FAIL settrig_addr%0d got=%0d/%0d want=%0d/%0d", a, PGA1, PGA2, e[5:3], e[2:0]);
            end
        end
    endtask

    task automatic test_calibrate();
        int dc, nd, nb; bit to; logic [5:0] e;
        sv_en = 1'b1; ovf1_mode = 1'b1; ovf2_mode = 1'b0;
        start_cal();
        checks++;
        if ({CalActive, PGA1, PGA2} !== 7'b1111111) begin
            failures++; $display("FAIL cal_start got act=%b pga=%0d/%0d want 1 7/7", CalActive, PGA1, PGA2);
        end
        wait_cal(40000, dc, to, nd, nb);
        checks++;
        if (to !== 1'b0 || dc != 1) begin
            failures++; $display("FAIL cal_done got timeout=%b pulses=%0d want 0/1", to, dc);
        end
        checks++;
        if ({CalActive, CalErr} !== 3'b000) begin
            failures++; $display("FAIL cal_end_flags got act=%b err=%b want 0/00", CalActive, CalErr);
        end
        for (int a = 1; a <= NM; a++) begin
            drive_addr(9'(a), G_CH1_FOUND, G_TOP);
            e = sbq.pop_front();
            checks++;
            if ({PGA1, PGA2} !== e) begin
                failures++; $display("FAIL cal_tab%0d got=%0d/%0d want=%0d/%0d", a, PGA1, PGA2, e[5:3], e[2:0]);
            end
        end
    endtask

    task automatic test_cal_error();
        int dc, nd, nb; bit to; logic [5:0] e;
        ovf1_mode = 1'b0; ovf2_mode = 1'b1;
        start_cal();
        wait_cal(60000, dc, to, nd, nb);
        checks++;
        if (nd != 7 || nb != 0) begin
            failures++; $display("FAIL err_walk got steps=%0d bad=%0d want 7/0", nd, nb);
        end
        checks++;
        if (to !== 1'b0 || dc != 1) begin
            failures++; $display("FAIL err_done got timeout=%b pulses=%0d want 0/1", to, dc);
        end
        checks++;
        if (CalErr !== 2'b10) begin
            failures++; $display("FAIL err_flag got=%b want=10", CalErr);
        end
        for (int a = 1; a <= NM; a++) begin
            drive_addr(9'(a), G_TOP, 3'd0);
            e = sbq.pop_front();
            checks++;
            if ({PGA1, PGA2} !== e) begin
                failures++; $display("FAIL err_tab%0d got=%0d/%0d want=%0d/%0d", a, PGA1, PGA2, e[5:3], e[2:0]);
            end
        end
    endtask

    task automatic test_abort();
        int dc; logic [5:0] e;
        ovf1_mode = 1'b1; ovf2_mode = 1'b0;
        CalStart = 1'b1; CalAbort = 1'b1;
        tick();
        CalStart = 1'b0; CalAbort = 1'b0;
        tick();
        checks++;
        if (CalActive !== 1'b0) begin
            failures++; $display("FAIL abort_wins got act=%b want=0", CalActive);
        end
        start_cal();
        Cmd = 16'h1100;
        SetTrig = 1'b1;
        tick();
        SetTrig = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (CalAddr == 9'd3) break;
            tick();
        end
        checks++;
        if (CalAddr !== 9'd3) begin
            failures++; $display("FAIL abort_reach got addr=%0d want=3", CalAddr);
        end
        CalAbort = 1'b1;
        tick();
        CalAbort = 1'b0;
        checks++;
        if (CalActive !== 1'b0) begin
            failures++; $display("FAIL abort_idle got act=%b want=0", CalActive);
        end
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (CalDone) dc++;
        end
        checks++;
        if (dc != 0 || CalActive !== 1'b0 || CalErr !== 2'b00) begin
            failures++; $display("FAIL abort_quiet got pulses=%0d act=%b err=%b want 0/0/00", dc, CalActive, CalErr);
        end
        for (int a = 1; a <= NM; a++) begin
            if (a <= 2) drive_addr(9'(a), G_CH1_FOUND, G_TOP);
            else        drive_addr(9'(a), G_TOP, 3'd0);
            e = sbq.pop_front();
            checks++;
            if ({PGA1, PGA2} !== e) begin
                failures++; $display("FAIL abort_tab%0d got=%0d/%0d want=%0d/%0d", a, PGA1, PGA2, e[5:3], e[2:0]);
            end
        end
    endtask

    task automatic test_range_and_async_reset();
        logic [5:0] e;
        drive_addr(9'd0, 3'd3, 3'd3);
        e = sbq.pop_front();
        checks++;
        if ({PGA1, PGA2} !== e) begin
            failures++; $display("FAIL addr0 got=%0d/%0d want=3/3", PGA1, PGA2);
        end
        drive_addr(9'd67, 3'd3, 3'd3);
        e = sbq.pop_front();
        checks++;
        if ({PGA1, PGA2} !== e) begin
            failures++; $display("FAIL addr67 got=%0d/%0d want=3/3", PGA1, PGA2);
        end
        ovf1_mode = 1'b1; ovf2_mode = 1'b1;
        SwitchAddr = 9'd2;
        start_cal();
        for (int i = 0; i < ST + 6; i++) tick();
        checks++;
        if (CalActive !== 1'b1) begin
            failures++; $display("FAIL mid_sweep got act=%b want=1", CalActive);
        end
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if ({PGA1, PGA2, CalActive, CalDone, CalErr, CalAddr} !== {3'd3, 3'd3, 1'b0, 1'b0, 2'b00, 9'd1}) begin
            failures++; $display("FAIL async_rst got pga=%0d/%0d act=%b done=%b err=%b addr=%0d want 3/3 0 0 00 1",
                                 PGA1, PGA2, CalActive, CalDone, CalErr, CalAddr);
        end
        tick();
        RST = 1'b1;
        ovf1_mode = 1'b0; ovf2_mode = 1'b0;
        drive_addr(9'd1, 3'd3, 3'd3);
        e = sbq.pop_front();
        checks++;
        if ({PGA1, PGA2} !== e) begin
            failures++; $display("FAIL rst_table got=%0d/%0d want=3/3", PGA1, PGA2);
        end
    endtask

    initial begin
        test_reset();
        test_settrig();
        test_calibrate();
        test_cal_error();
        test_abort();
        test_range_and_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
